// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver: FSM state encoding and framing constants.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    STOP    = 3'd3,
    CLEANUP = 3'd4
  } uart_state_e;

  localparam int DATA_BITS            = 8;
  localparam int DEFAULT_CLKS_PER_BIT = 2605;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous bit; reset value selectable.
module sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first, mid-bit sampling of a synchronized RX line.
// Output handshake: data_valid is a one-clock strobe with output_stream already updated; there is no backpressure.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int CNT_W        = 16
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        input_stream,
  output logic [7:0]  output_stream,
  output logic        data_valid,
  output logic        frame_error,
  output uart_state_e state_o
);

  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       LAST_BIT = 3'(DATA_BITS - 1);

  logic rx_s;

  uart_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_q, data_d;
  logic             dv_q, dv_d;
  logic             fe_q, fe_d;

  // Idle line is high, so the synchronizer resets to 1 to avoid a false start bit.
  sync2 #(.RESET_VAL(1'b1)) u_sync (
    .clk_i  (clock),
    .rst_ni (reset_n),
    .d_i    (input_stream),
    .q_o    (rx_s)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      dv_q      <= 1'b0;
      fe_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      dv_q      <= dv_d;
      fe_q      <= fe_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    data_d    = data_q;
    dv_d      = 1'b0;
    fe_d      = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d     = '0;
        bit_idx_d = '0;
        if (!rx_s) state_d = START;
      end
      START: begin
        // A start bit that is gone by mid-bit is treated as line noise.
        if (cnt_q == HALF_CNT) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = rx_s ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DATA: begin
        if (cnt_q == FULL_CNT) begin
          cnt_d            = '0;
          shift_d[bit_idx_q] = rx_s;
          if (bit_idx_q == LAST_BIT) state_d = STOP;
          else                       bit_idx_d = bit_idx_q + 3'd1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      STOP: begin
        if (cnt_q == FULL_CNT) begin
          cnt_d   = '0;
          state_d = CLEANUP;
          if (rx_s) begin
            data_d = shift_q;
            dv_d   = 1'b1;
          end else begin
            fe_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      CLEANUP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign output_stream = data_q;
  assign data_valid    = dv_q;
  assign frame_error   = fe_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx with a shortened bit time (50 clocks of 40 ns = 2000 ns per bit).
module tb_uart_rx;
  import uart_pkg::*;

  localparam int CPB    = 50;
  localparam int BIT_NS = 2000;

  logic        clock;
  logic        reset_n;
  logic        input_stream;
  logic [7:0]  output_stream;
  logic        data_valid;
  logic        frame_error;
  uart_state_e dbg_state;

  int vectors    = 0;
  int miscompares = 0;
  int dv_cnt     = 0;
  int fe_cnt     = 0;

  uart_rx #(.CLKS_PER_BIT(CPB), .CNT_W(16)) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .input_stream  (input_stream),
    .output_stream (output_stream),
    .data_valid    (data_valid),
    .frame_error   (frame_error),
    .state_o       (dbg_state)
  );

  // Clock / reset block
  initial begin
    clock = 1'b0;
    forever #20 clock = ~clock;
  end

  // Pulse counters: counting on every falling edge also catches strobes wider than one clock.
  always @(negedge clock) begin
    if (data_valid)  dv_cnt <= dv_cnt + 1;
    if (frame_error) fe_cnt <= fe_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, input logic stop_bit, input int bit_ns);
    input_stream = 1'b0;
    #(bit_ns);
    for (int i = 0; i < 8; i++) begin
      input_stream = b[i];
      #(bit_ns);
    end
    input_stream = stop_bit;
    #(bit_ns);
  endtask

  initial begin
    reset_n      = 1'b0;
    input_stream = 1'b1;
    #105;
    check("reset_out",   32'(output_stream), 32'h00);
    check("reset_dv",    32'(data_valid),    32'h0);
    check("reset_fe",    32'(frame_error),   32'h0);
    check("reset_state", 32'(dbg_state),     32'(IDLE));
    reset_n = 1'b1;
    #(2*BIT_NS);

    // Start-bit glitch of a quarter bit
    input_stream = 1'b0;
    #(BIT_NS/4);
    input_stream = 1'b1;
    #(3*BIT_NS);
    check("glitch_dv",    32'(dv_cnt),        32'd0);
    check("glitch_out",   32'(output_stream), 32'h00);
    check("glitch_state", 32'(dbg_state),     32'(IDLE));
    check("glitch_fe",    32'(fe_cnt),        32'd0);

    // Basic frame
    send(8'b1001_0011, 1'b1, BIT_NS);
    check("basic_out", 32'(output_stream), 32'h93);
    check("basic_dv",  32'(dv_cnt),        32'd1);
    check("basic_fe",  32'(fe_cnt),        32'd0);
    #(BIT_NS);

    // Back-to-back frames, no idle gap
    send(8'h5A, 1'b1, BIT_NS);
    check("b2b_out0", 32'(output_stream), 32'h5A);
    send(8'hA5, 1'b1, BIT_NS);
    check("b2b_out1", 32'(output_stream), 32'hA5);
    #(BIT_NS);
    check("b2b_dv",   32'(dv_cnt),        32'd3);

    // Framing error, then recovery
    send(8'hFF, 1'b0, BIT_NS);
    check("ferr_fe",  32'(fe_cnt),        32'd1);
    check("ferr_out", 32'(output_stream), 32'hA5);
    check("ferr_dv",  32'(dv_cnt),        32'd3);
    input_stream = 1'b1;
    #(2*BIT_NS);
    check("ferr_state", 32'(dbg_state), 32'(IDLE));
    send(8'h3C, 1'b1, BIT_NS);
    check("ferr_next_out", 32'(output_stream), 32'h3C);
    check("ferr_next_dv",  32'(dv_cnt),        32'd4);
    #(BIT_NS);

    // Reset during data bit 4
    input_stream = 1'b0;
    #(BIT_NS);
    for (int i = 0; i < 4; i++) begin
      input_stream = ~input_stream;
      #(BIT_NS);
    end
    input_stream = 1'b0;
    #(BIT_NS/2);
    reset_n = 1'b0;
    #1;
    check("rst_mid_out",   32'(output_stream), 32'h00);
    check("rst_mid_state", 32'(dbg_state),     32'(IDLE));
    #(BIT_NS);
    input_stream = 1'b1;
    reset_n      = 1'b1;
    #(2*BIT_NS);
    send(8'hC3, 1'b1, BIT_NS);
    check("rst_next_out", 32'(output_stream), 32'hC3);
    check("rst_next_dv",  32'(dv_cnt),        32'd5);
    #(BIT_NS);

    // Baud tolerance, -2% and +2%
    send(8'h96, 1'b1, 1960);
    check("fast_out", 32'(output_stream), 32'h96);
    check("fast_dv",  32'(dv_cnt),        32'd6);
    #(BIT_NS);
    send(8'h96, 1'b1, 2040);
    check("slow_out", 32'(output_stream), 32'h96);
    check("slow_dv",  32'(dv_cnt),        32'd7);
    #(BIT_NS);
    check("final_fe",    32'(fe_cnt),    32'd1);
    check("final_state", 32'(dbg_state), 32'(IDLE));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
